// File: rtl/gpio_pwm_block.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pwm_block
// Purpose  : Bus-mapped GPIO with per-channel PWM, edge interrupts and a
//            2-flop input synchroniser. Read data is OR-combinable on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_pwm_block #(
  parameter int pBlockAdrsMap = 8,
  parameter int pAdrsMap      = 'h01,
  parameter int pBusAdrsBit   = 32,
  parameter int pGpioWidth    = 8,
  parameter int pPwmBit       = 8
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic [pGpioWidth-1:0]  iGpio,
  output logic [pGpioWidth-1:0]  oGpio,
  output logic [pGpioWidth-1:0]  oGpioOe,
  output logic                   oIrq,
  output logic [31:0]            oSUsiRd,
  output logic                   oSUsiVd,
  input  logic [31:0]            iSUsiWd,
  input  logic [pBusAdrsBit-1:0] iSUsiAdrs,
  input  logic                   iSUsiWCke
);

  localparam logic [7:0] OFS_OUT  = 8'h00;
  localparam logic [7:0] OFS_DIR  = 8'h04;
  localparam logic [7:0] OFS_IN   = 8'h08;
  localparam logic [7:0] OFS_PEN  = 8'h0C;
  localparam logic [7:0] OFS_DIV  = 8'h10;
  localparam logic [7:0] OFS_REN  = 8'h14;
  localparam logic [7:0] OFS_FEN  = 8'h18;
  localparam logic [7:0] OFS_IRQ  = 8'h1C;

  // Bus decode
  logic                  sel, wr, rd_req;
  logic [7:0]            ofs;
  logic                  duty_win;
  logic [5:0]            duty_idx;
  logic [pGpioWidth-1:0] duty_sel;
  logic [pGpioWidth-1:0] wd_g;
  logic [pPwmBit-1:0]    wd_duty;

  // Programmer-visible state
  logic [pGpioWidth-1:0] gpio_out, gpio_dir, pwm_en, rise_en, fall_en, irq_stat;
  logic [15:0]           pwm_div;
  logic [pPwmBit-1:0]    duty   [pGpioWidth];
  logic [pPwmBit-1:0]    shadow [pGpioWidth];

  // Input path and timebase
  logic [pGpioWidth-1:0] sync1, sync2, prev, irq_set, irq_clr, pwm;
  logic [15:0]           presc;
  logic [pPwmBit-1:0]    cnt;
  logic                  div_wr, tick, wrap;
  logic [31:0]           rd_next;
  logic                  unused_bits;

  assign sel      = (iSUsiAdrs[pBusAdrsBit-1 -: pBlockAdrsMap] == pBlockAdrsMap'(pAdrsMap));
  assign ofs      = iSUsiAdrs[7:0];
  assign wr       = sel & iSUsiWCke;
  assign rd_req   = sel & ~iSUsiWCke;
  assign wd_g     = iSUsiWd[pGpioWidth-1:0];
  assign wd_duty  = iSUsiWd[pPwmBit-1:0];
  assign duty_win = (ofs[7:6] != 2'b00) && (ofs[1:0] == 2'b00);
  assign duty_idx = ofs[7:2] - 6'd16;

  // Only the block-select field, the offset byte and the mapped data bits matter
  assign unused_bits = &{1'b0, iSUsiAdrs, iSUsiWd};

  // Edge detection on the synchronised pins; a same-cycle set beats a clear
  assign irq_set = (sync2 & ~prev & rise_en) | (~sync2 & prev & fall_en);
  assign irq_clr = (wr && ofs == OFS_IRQ) ? wd_g : '0;

  // A PWM_DIV write restarts the prescaler and swallows that cycle's tick
  assign div_wr = wr && (ofs == OFS_DIV);
  assign tick   = ~div_wr && (presc == pwm_div);
  assign wrap   = tick && (cnt == '1);

  for (genvar i = 0; i < pGpioWidth; i++) begin : g_chan
    assign duty_sel[i] = duty_win && (duty_idx == 6'(i));
    assign pwm[i]      = (cnt < shadow[i]);
  end

  // Control registers written from the bus
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      gpio_out <= '0;
      gpio_dir <= '0;
      pwm_en   <= '0;
      pwm_div  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr) begin
      case (ofs)
        OFS_OUT: gpio_out <= wd_g;
        OFS_DIR: gpio_dir <= wd_g;
        OFS_PEN: pwm_en   <= wd_g;
        OFS_DIV: pwm_div  <= iSUsiWd[15:0];
        OFS_REN: rise_en  <= wd_g;
        OFS_FEN: fall_en  <= wd_g;
        default: ;
      endcase
    end
  end

  // Duty registers and their shadows, which only reload as the counter wraps
  always_ff @(posedge iSysClk) begin
    for (int i = 0; i < pGpioWidth; i++) begin
      if (iSysRst) begin
        duty[i]   <= '0;
        shadow[i] <= '0;
      end else begin
        if (wr && duty_sel[i]) duty[i] <= wd_duty;
        if (wrap)              shadow[i] <= duty[i];
      end
    end
  end

  // Pin synchroniser, previous-value flop and sticky interrupt status
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      irq_stat <= '0;
    end else begin
      sync1    <= iGpio;
      sync2    <= sync1;
      prev     <= sync2;
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
    end
  end

  // Prescaler and PWM period counter
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      if (div_wr || tick) presc <= '0;
      else                presc <= presc + 16'd1;
      if (tick)           cnt   <= cnt + 1'b1;
    end
  end

  // Read multiplexer; unmapped offsets return zero
  always_comb begin
    rd_next = '0;
    case (ofs)
      OFS_OUT: rd_next = 32'(gpio_out);
      OFS_DIR: rd_next = 32'(gpio_dir);
      OFS_IN:  rd_next = 32'(sync2);
      OFS_PEN: rd_next = 32'(pwm_en);
      OFS_DIV: rd_next = 32'(pwm_div);
      OFS_REN: rd_next = 32'(rise_en);
      OFS_FEN: rd_next = 32'(fall_en);
      OFS_IRQ: rd_next = 32'(irq_stat);
      default: begin
        for (int i = 0; i < pGpioWidth; i++) begin
          if (duty_sel[i]) rd_next = 32'(duty[i]);
        end
      end
    endcase
  end

  // Registered pin, interrupt and bus outputs
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      oGpio   <= '0;
      oGpioOe <= '0;
      oIrq    <= 1'b0;
      oSUsiRd <= '0;
      oSUsiVd <= 1'b0;
    end else begin
      oGpio   <= (pwm_en & pwm) | (~pwm_en & gpio_out);
      oGpioOe <= gpio_dir;
      oIrq    <= |irq_stat;
      oSUsiRd <= rd_req ? rd_next : 32'd0;
      oSUsiVd <= rd_req;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_pwm_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pwm_block
// Purpose  : Self-checking bench for gpio_pwm_block: cycle model compared on
//            every falling edge plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_pwm_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_o, gpio_oe;
  logic        irq_o;
  logic [31:0] rd_o;
  logic        vd_o;
  logic [31:0] wd;
  logic [31:0] adrs;
  logic        wcke;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpio_pwm_block #(
    .pBlockAdrsMap(8), .pAdrsMap('h01), .pBusAdrsBit(32), .pGpioWidth(8), .pPwmBit(8)
  ) dut (
    .iSysClk(clk), .iSysRst(rst), .iGpio(gpio_in),
    .oGpio(gpio_o), .oGpioOe(gpio_oe), .oIrq(irq_o),
    .oSUsiRd(rd_o), .oSUsiVd(vd_o),
    .iSUsiWd(wd), .iSUsiAdrs(adrs), .iSUsiWCke(wcke)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  m_out, m_dir, m_pen, m_ren, m_fen, m_irq, m_set, m_pw;
  logic [15:0] m_div;
  int          m_duty [8];
  int          m_shadow [8];
  int          m_presc, m_cnt;
  logic [7:0]  hist [3];           // pin samples taken at the last three edges
  logic [7:0]  e_gpio, e_oe;
  logic        e_irq, e_vd;
  logic [31:0] e_rd;
  logic        m_valid = 1'b0;
  logic        m_sel, m_wr, m_rdq;
  logic [7:0]  m_o;

  function automatic logic [31:0] m_read(input logic [7:0] o);
    case (o)
      8'h00: return {24'd0, m_out};
      8'h04: return {24'd0, m_dir};
      8'h08: return {24'd0, hist[1]};
      8'h0C: return {24'd0, m_pen};
      8'h10: return {16'd0, m_div};
      8'h14: return {24'd0, m_ren};
      8'h18: return {24'd0, m_fen};
      8'h1C: return {24'd0, m_irq};
      default: begin
        if (o >= 8'h40 && o[1:0] == 2'b00 && ((o - 8'h40) >> 2) < 8)
          return 32'(m_duty[(o - 8'h40) >> 2]);
        return 32'd0;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    m_sel = (adrs[31:24] == 8'h01);
    m_o   = adrs[7:0];
    m_wr  = m_sel && wcke;
    m_rdq = m_sel && !wcke;
    if (rst) begin
      {m_out, m_dir, m_pen, m_ren, m_fen, m_irq} = '0;
      m_div = '0; m_presc = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
      for (int i = 0; i < 3; i++) hist[i] = '0;
      e_gpio = '0; e_oe = '0; e_irq = 1'b0; e_rd = '0; e_vd = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) m_pw[i] = (m_cnt < m_shadow[i]);
      e_gpio = (m_pen & m_pw) | (~m_pen & m_out);
      e_oe   = m_dir;
      e_irq  = |m_irq;
      e_rd   = m_rdq ? m_read(m_o) : 32'd0;
      e_vd   = m_rdq;
      // an edge seen on the synchronised pin value
      m_set = (hist[1] & ~hist[2] & m_ren) | (~hist[1] & hist[2] & m_fen);
      // timebase: divide by PWM_DIV+1, 256-step period, duties latch at period start
      if (m_wr && m_o == 8'h10) m_presc = 0;
      else if (m_presc == int'(m_div)) begin
        m_presc = 0;
        m_cnt   = (m_cnt + 1) % 256;
        if (m_cnt == 0) for (int i = 0; i < 8; i++) m_shadow[i] = m_duty[i];
      end else m_presc++;
      m_irq = (m_irq & ~((m_wr && m_o == 8'h1C) ? wd[7:0] : 8'h00)) | m_set;
      if (m_wr) begin
        case (m_o)
          8'h00: m_out = wd[7:0];
          8'h04: m_dir = wd[7:0];
          8'h0C: m_pen = wd[7:0];
          8'h10: m_div = wd[15:0];
          8'h14: m_ren = wd[7:0];
          8'h18: m_fen = wd[7:0];
          default: if (m_o >= 8'h40 && m_o[1:0] == 2'b00 && ((m_o - 8'h40) >> 2) < 8)
                     m_duty[(m_o - 8'h40) >> 2] = int'(wd[7:0]);
        endcase
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = gpio_in;
    end
    m_valid = 1'b1;
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if ({gpio_o, gpio_oe, irq_o, rd_o, vd_o} !== {e_gpio, e_oe, e_irq, e_rd, e_vd}) begin
        fails++;
        if (fails <= 20)
          $display("FAIL model_cmp t=%0t gpio=%h/%h oe=%h/%h irq=%b/%b rd=%h/%h vd=%b/%b (got/expected)",
                   $time, gpio_o, e_gpio, gpio_oe, e_oe, irq_o, e_irq, rd_o, e_rd, vd_o, e_vd);
      end
    end
  end

  // ---------------- directed helpers (called at a falling edge) ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] o, input logic [31:0] d);
    adrs = {8'h01, 16'h0000, o}; wd = d; wcke = 1'b1;
    @(negedge clk);
    adrs = '0; wd = '0; wcke = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] blk, input logic [7:0] o,
                        output logic [31:0] d, output logic v);
    adrs = {blk, 16'h0000, o}; wcke = 1'b0;
    @(negedge clk);
    d = rd_o; v = vd_o;
    adrs = '0;
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int j = 0; j < n; j++) begin
      c += int'(gpio_o[2]);
      @(negedge clk);
    end
  endtask

  logic [7:0]  offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h48};
  logic [31:0] d;
  logic        v, pv;
  int          c;
  logic        found;

  initial begin
    rst = 1'b1; gpio_in = '0; adrs = '0; wd = '0; wcke = 1'b0;
    repeat (2) @(negedge clk);
    bus_wr(8'h00, 32'hFF);                      // lands during reset, must vanish
    check("rst_gpio", {24'd0, gpio_o}, 32'h0);
    check("rst_oe",   {24'd0, gpio_oe}, 32'h0);
    check("rst_vd",   {31'd0, vd_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    foreach (offs[k]) begin
      bus_rd(8'h01, offs[k], d, v);
      check($sformatf("rst_read_%02h", offs[k]), d, 32'h0);
    end

    // direction / output data / readback
    bus_wr(8'h04, 32'hFF); @(negedge clk);
    check("oe_ff", {24'd0, gpio_oe}, 32'hFF);
    bus_wr(8'h00, 32'hA5); @(negedge clk);
    check("gpio_a5", {24'd0, gpio_o}, 32'hA5);
    bus_rd(8'h01, 8'h00, d, v);
    check("rd_out", d, 32'hA5); check("rd_out_vd", {31'd0, v}, 32'h1);
    bus_wr(8'h00, 32'hFFFF_FF5A); bus_rd(8'h01, 8'h00, d, v);
    check("out_width_mask", d, 32'h5A);
    bus_wr(8'h08, 32'hFF); bus_rd(8'h01, 8'h08, d, v);
    check("in_write_ignored", d, 32'h0);
    bus_wr(8'h3C, 32'hFF); bus_rd(8'h01, 8'h3C, d, v);
    check("unmapped_rd", d, 32'h0); check("unmapped_vd", {31'd0, v}, 32'h1);
    bus_rd(8'h02, 8'h00, d, v);
    check("nosel_rd", d, 32'h0); check("nosel_vd", {31'd0, v}, 32'h0);
    bus_wr(8'h40, 32'h1FF); bus_rd(8'h01, 8'h40, d, v);
    check("duty_width_mask", d, 32'hFF);
    bus_wr(8'h10, 32'h12345); bus_rd(8'h01, 8'h10, d, v);
    check("div_width_mask", d, 32'h2345);

    // rising-edge interrupt
    bus_wr(8'h14, 32'h01);
    gpio_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_rd(8'h01, 8'h08, d, v);  check("in_sync", d, 32'h01);
    bus_rd(8'h01, 8'h1C, d, v);  check("irq_stat_set", d, 32'h01);
    check("irq_out", {31'd0, irq_o}, 32'h1);
    bus_wr(8'h1C, 32'h01); bus_rd(8'h01, 8'h1C, d, v);
    check("irq_w1c", d, 32'h0);
    // clear on the same cycle as a new rising edge: set wins
    gpio_in[0] = 1'b0; repeat (4) @(negedge clk);
    gpio_in[0] = 1'b1; repeat (2) @(negedge clk);
    bus_wr(8'h1C, 32'h01); bus_rd(8'h01, 8'h1C, d, v);
    check("irq_set_wins", d, 32'h01);
    bus_wr(8'h1C, 32'hFF);
    // falling-edge interrupt
    bus_wr(8'h14, 32'h00); bus_wr(8'h18, 32'h01);
    gpio_in[0] = 1'b0; repeat (4) @(negedge clk);
    bus_rd(8'h01, 8'h1C, d, v);  check("irq_fall", d, 32'h01);
    bus_wr(8'h1C, 32'hFF); bus_wr(8'h18, 32'h00);

    // PWM, divider 0
    bus_wr(8'h00, 32'h00); bus_wr(8'h10, 32'h0); bus_wr(8'h48, 32'd64); bus_wr(8'h0C, 32'h04);
    repeat (300) @(negedge clk);
    count_high(256, c); check("pwm_duty64", c, 32'd64);
    bus_wr(8'h48, 32'd0);   repeat (300) @(negedge clk);
    count_high(256, c); check("pwm_duty0", c, 32'd0);
    bus_wr(8'h48, 32'd255); repeat (300) @(negedge clk);
    count_high(256, c); check("pwm_duty255", c, 32'd255);

    // PWM, divider 3: period 1024, duty change deferred to next period
    bus_wr(8'h48, 32'd64); bus_wr(8'h10, 32'd3);
    repeat (1100) @(negedge clk);
    found = 1'b0; pv = gpio_o[2];
    for (int k = 0; k < 1100 && !found; k++) begin
      @(negedge clk);
      if (!pv && gpio_o[2]) found = 1'b1;
      pv = gpio_o[2];
    end
    check("pwm_rise_found", {31'd0, found}, 32'h1);
    c = 0;
    for (int j = 0; j < 1024; j++) begin
      c += int'(gpio_o[2]);
      if (j == 20) begin adrs = {8'h01, 16'h0, 8'h48}; wd = 32'd192; wcke = 1'b1; end
      if (j == 21) begin adrs = '0; wd = '0; wcke = 1'b0; end
      @(negedge clk);
    end
    check("pwm_div3_period_unchanged", c, 32'd256);
    count_high(1024, c); check("pwm_div3_new_duty", c, 32'd768);

    // reset mid-PWM with an interrupt pending
    bus_wr(8'h14, 32'h01);
    gpio_in[0] = 1'b1; repeat (5) @(negedge clk);
    check("irq_before_rst", {31'd0, irq_o}, 32'h1);
    rst = 1'b1; gpio_in = '0;
    @(negedge clk);
    check("rst_mid_outputs", {gpio_o, gpio_oe, 7'd0, irq_o, 7'd0, vd_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    foreach (offs[k]) begin
      bus_rd(8'h01, offs[k], d, v);
      check($sformatf("post_rst_read_%02h", offs[k]), d, 32'h0);
    end
    repeat (300) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
